// File: rtl/mdu_pkg.sv
// Shared types and op-decode helpers for the RV32M multiply/divide unit.
package mdu_pkg;

  typedef enum logic [2:0] {
    MDU_MUL, MDU_MULH, MDU_MULHSU, MDU_MULHU,
    MDU_DIV, MDU_DIVU, MDU_REM,    MDU_REMU
  } mdu_op_t;

  typedef enum logic [1:0] {
    MDU_IDLE, MDU_CALC, MDU_DONE
  } mdu_state_t;

  function automatic logic op_is_div(input mdu_op_t op);
    return op[2];
  endfunction

  function automatic logic op_is_rem(input mdu_op_t op);
    return op[2] & op[1];
  endfunction

  function automatic logic src1_signed(input mdu_op_t op);
    return (op == MDU_MULH) || (op == MDU_MULHSU) || (op == MDU_DIV) || (op == MDU_REM);
  endfunction

  function automatic logic src2_signed(input mdu_op_t op);
    return (op == MDU_MULH) || (op == MDU_DIV) || (op == MDU_REM);
  endfunction

endpackage

// File: rtl/mdu.sv
// Multi-cycle RV32M multiply/divide: shift-add multiply and restoring divide,
// one bit per cycle on a shared 2*XLEN accumulator.
//
// state    | meaning
// ---------+-----------------------------------------------
// MDU_IDLE | ready for a new op
// MDU_CALC | one multiply/divide step per cycle, XLEN steps
// MDU_DONE | result presented until out_ready
module mdu
  import mdu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  mdu_op_t         op,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            busy
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
  localparam logic [XLEN-1:0] MIN_VAL  = {1'b1, {(XLEN-1){1'b0}}};

  mdu_state_t          state_q, state_d;
  mdu_op_t             op_q;
  logic [2*XLEN-1:0]   acc_q, acc_nx, prod_s;
  logic [XLEN-1:0]     b_q, result_q, quo_s, rem_s, final_val;
  logic                neg_q;
  logic [CW-1:0]       count_q;

  logic                accept, special, s1_neg, s2_neg, neg_in, is_div_in, q_div;
  logic [XLEN-1:0]     mag1, mag2, special_val;
  logic [XLEN:0]       rem_sh;
  logic [XLEN+1:0]     a_op, b_op, sum;

  assign s1_neg    = src1_signed(op) & src1[XLEN-1];
  assign s2_neg    = src2_signed(op) & src2[XLEN-1];
  assign mag1      = s1_neg ? -src1 : src1;
  assign mag2      = s2_neg ? -src2 : src2;
  assign is_div_in = op_is_div(op);
  assign neg_in    = op_is_rem(op) ? s1_neg : (s1_neg ^ s2_neg);

  always_comb begin
    special     = 1'b0;
    special_val = '0;
    if (is_div_in) begin
      if (src2 == '0) begin
        special     = 1'b1;
        special_val = op[1] ? src1 : '1;
      end else if (src2_signed(op) && (src1 == MIN_VAL) && (src2 == '1)) begin
        special     = 1'b1;
        special_val = op[1] ? '0 : src1;
      end
    end else if ((src1 == '0) || (src2 == '0)) begin
      special = 1'b1;
    end
  end

  assign accept = in_valid && (state_q == MDU_IDLE) && !flush;

  always_ff @(posedge clk) begin
    if (rst) state_q <= MDU_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      MDU_IDLE: if (accept) state_d = special ? MDU_DONE : MDU_CALC;
      MDU_CALC: if (count_q == '0) state_d = MDU_DONE;
      MDU_DONE: if (out_ready) state_d = MDU_IDLE;
      default:  state_d = MDU_IDLE;
    endcase
    if (flush) state_d = MDU_IDLE;
  end

  // Shared adder: subtract divisor when dividing, add gated multiplicand when multiplying.
  assign q_div  = op_is_div(op_q);
  assign rem_sh = acc_q[2*XLEN-1:XLEN-1];
  assign a_op   = q_div ? {1'b0, rem_sh} : {2'b00, acc_q[2*XLEN-1:XLEN]};
  assign b_op   = (q_div || acc_q[0]) ? {2'b00, b_q} : '0;
  assign sum    = a_op + (b_op ^ {(XLEN+2){q_div}}) + {{(XLEN+1){1'b0}}, q_div};

  always_comb begin
    if (q_div) begin
      if (!sum[XLEN+1]) acc_nx = {sum[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
      else              acc_nx = {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    end else begin
      acc_nx = {sum[XLEN:0], acc_q[XLEN-1:1]};
    end
  end

  assign prod_s = neg_q ? -acc_nx : acc_nx;
  assign quo_s  = neg_q ? -acc_nx[XLEN-1:0] : acc_nx[XLEN-1:0];
  assign rem_s  = neg_q ? -acc_nx[2*XLEN-1:XLEN] : acc_nx[2*XLEN-1:XLEN];

  always_comb begin
    case (op_q)
      MDU_MUL:             final_val = prod_s[XLEN-1:0];
      MDU_DIV, MDU_DIVU:   final_val = quo_s;
      MDU_REM, MDU_REMU:   final_val = rem_s;
      default:             final_val = prod_s[2*XLEN-1:XLEN];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q    <= '0;
      b_q      <= '0;
      op_q     <= MDU_MUL;
      neg_q    <= 1'b0;
      count_q  <= '0;
      result_q <= '0;
    end else if (!flush) begin
      if (accept) begin
        op_q    <= op;
        neg_q   <= neg_in;
        count_q <= CNT_LAST;
        // Multiplier sits in the low half; b_q holds the operand the adder consumes.
        acc_q   <= {{XLEN{1'b0}}, is_div_in ? mag1 : mag2};
        b_q     <= is_div_in ? mag2 : mag1;
        if (special) result_q <= special_val;
      end else if (state_q == MDU_CALC) begin
        acc_q   <= acc_nx;
        count_q <= count_q - CNT_ONE;
        if (count_q == '0) result_q <= final_val;
      end
    end
  end

  assign in_ready  = (state_q == MDU_IDLE);
  assign out_valid = (state_q == MDU_DONE);
  assign busy      = (state_q != MDU_IDLE);
  assign result    = result_q;
  assign zero      = (result_q == '0);

endmodule

// File: tb/tb_mdu.sv
// Directed and randomised checks of the mdu: results, latency, stall, flush, reset.
module tb_mdu;
  import mdu_pkg::*;

  localparam int XLEN = 32;
  localparam logic [31:0] MINV = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  mdu_op_t     op = MDU_MUL;
  logic [31:0] src1 = '0;
  logic [31:0] src2 = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        zero;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;

  mdu #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .src1(src1), .src2(src2), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_model(input mdu_op_t o, input logic [31:0] a, input logic [31:0] b);
    longint      sa = longint'($signed(a));
    longint      sb = longint'($signed(b));
    longint      ub = longint'({32'b0, b});
    logic [63:0] ua = {32'b0, a};
    logic [63:0] p;
    int          q;
    case (o)
      MDU_MUL:    begin p = ua * {32'b0, b}; return p[31:0]; end
      MDU_MULH:   begin p = sa * sb; return p[63:32]; end
      MDU_MULHSU: begin p = sa * ub; return p[63:32]; end
      MDU_MULHU:  begin p = ua * {32'b0, b}; return p[63:32]; end
      MDU_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == MINV && b == 32'hFFFF_FFFF) return a;
        q = $signed(a) / $signed(b); return q;
      end
      MDU_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      MDU_REM: begin
        if (b == 0) return a;
        if (a == MINV && b == 32'hFFFF_FFFF) return 32'h0;
        q = $signed(a) % $signed(b); return q;
      end
      default:  return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input mdu_op_t o, input logic [31:0] a, input logic [31:0] b);
    if (o == MDU_MUL || o == MDU_MULH || o == MDU_MULHSU || o == MDU_MULHU)
      return (a == 0 || b == 0) ? 0 : XLEN;
    if (b == 0) return 0;
    if ((o == MDU_DIV || o == MDU_REM) && a == MINV && b == 32'hFFFF_FFFF) return 0;
    return XLEN;
  endfunction

  // Present one op at a negedge and return after the accept edge, at the next negedge.
  task automatic start(input mdu_op_t o, input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    vectors++;
    if (!in_ready) begin
      miscompares++;
      $display("FAIL start_timeout: in_ready=%0b required 1", in_ready);
    end
    op = o; src1 = a; src2 = b; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic run_op(input mdu_op_t o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int exp_lat, input string name);
    int lat = 0;
    start(o, a, b);
    while (!out_valid && lat < 100) begin @(negedge clk); lat++; end
    vectors++;
    if (result !== exp) begin
      miscompares++;
      $display("FAIL %s result: got %h required %h", name, result, exp);
    end
    vectors++;
    if (lat !== exp_lat) begin
      miscompares++;
      $display("FAIL %s latency: got %0d required %0d", name, lat, exp_lat);
    end
    vectors++;
    if (zero !== (exp == 0)) begin
      miscompares++;
      $display("FAIL %s zero: got %0b required %0b", name, zero, (exp == 0));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s handoff: out_valid=%0b in_ready=%0b required 0,1", name, out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    vectors++;
    if ({in_ready, out_valid, zero, busy} !== 4'b1010) begin
      miscompares++;
      $display("FAIL reset_flags: in_ready,out_valid,zero,busy=%b required 1010", {in_ready, out_valid, zero, busy});
    end
    vectors++;
    if (result !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_result: got %h required 00000000", result);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mul();
    run_op(MDU_MUL,   32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 32, "mul_7_m3");
    run_op(MDU_MULH,  32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFFF, 32, "mulh_7_m3");
    run_op(MDU_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32, "mulhu_max");
    run_op(MDU_MUL,   32'd0,        32'd5,         32'h0,         0,  "mul_zero");
  endtask

  task automatic test_div();
    run_op(MDU_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32, "div_m7_2");
    run_op(MDU_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32, "rem_m7_2");
    run_op(MDU_DIVU, 32'd100,       32'd7, 32'd14,        32, "divu_100_7");
    run_op(MDU_REMU, 32'd100,       32'd7, 32'd2,         32, "remu_100_7");
  endtask

  task automatic test_special();
    run_op(MDU_DIV, 32'd5, 32'd0,         32'hFFFF_FFFF, 0, "div_by_0");
    run_op(MDU_REM, 32'd5, 32'd0,         32'd5,         0, "rem_by_0");
    run_op(MDU_DIV, MINV,  32'hFFFF_FFFF, MINV,          0, "div_ovf");
    run_op(MDU_REM, MINV,  32'hFFFF_FFFF, 32'h0,         0, "rem_ovf");
  endtask

  task automatic test_stall();
    int n = 0;
    start(MDU_DIVU, 32'd100, 32'd7);
    while (!out_valid && n < 100) begin @(negedge clk); n++; end
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (result !== 32'd14 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL stall_hold[%0d]: result=%h out_valid=%0b in_ready=%0b required 0000000e,1,0",
                 i, result, out_valid, in_ready);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    vectors++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL stall_release: busy=%0b out_valid=%0b in_ready=%0b required 0,0,1", busy, out_valid, in_ready);
    end
  endtask

  task automatic test_flush();
    int seen = 0;
    start(MDU_MUL, 32'd7, 32'd3);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    vectors++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || result !== 32'd14) begin
      miscompares++;
      $display("FAIL flush_calc: busy=%0b out_valid=%0b result=%h required 0,0,0000000e", busy, out_valid, result);
    end
    op = MDU_DIVU; src1 = 32'd9; src2 = 32'd3; in_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_blocks_accept: busy=%0b required 0", busy);
    end
    for (int i = 0; i < 40; i++) begin
      if (out_valid) seen++;
      @(negedge clk);
    end
    vectors++;
    if (seen !== 0) begin
      miscompares++;
      $display("FAIL flush_no_result: out_valid cycles=%0d required 0", seen);
    end
    run_op(MDU_MULHSU, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32, "mulhsu_after_flush");
  endtask

  task automatic test_rst();
    start(MDU_DIV, 32'd1000, 32'd3);
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if ({in_ready, out_valid, zero, busy} !== 4'b1010 || result !== 32'h0) begin
      miscompares++;
      $display("FAIL rst_mid_op: in_ready,out_valid,zero,busy=%b result=%h required 1010,00000000",
               {in_ready, out_valid, zero, busy}, result);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    mdu_op_t     o;
    logic [31:0] a, b;
    for (int i = 0; i < 24; i++) begin
      o = mdu_op_t'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      if (i % 5 == 0) b = 32'h0;
      if (i % 7 == 1) b = $urandom_range(1, 15);
      if (i % 6 == 2) a = 32'hFFFF_FFFF - $urandom_range(0, 100);
      if (i == 11) begin o = MDU_REM; a = MINV; b = 32'hFFFF_FFFF; end
      run_op(o, a, b, ref_model(o, a, b), ref_lat(o, a, b), $sformatf("rand%0d_%s", i, o.name()));
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_stall();
    test_flush();
    test_rst();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
